// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception controller.
//   exc_state_t : controller state encoding
//   CAUSE_*     : 4-bit cause codes presented on EStatus
package exc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      HANDLER,
      FAULT
   } exc_state_t;

   localparam logic [3:0] CAUSE_NONE   = 4'b0000;
   localparam logic [3:0] CAUSE_INVOP  = 4'b0001;
   localparam logic [3:0] CAUSE_EXTIRQ = 4'b0010;
   localparam logic [3:0] CAUSE_ERET   = 4'b0011;
   localparam logic [3:0] CAUSE_FAULT  = 4'b1111;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flip-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   - sampling clock, rising edge
//   reset - asynchronous active-high reset, clears every stage to 0
//   d_i   - asynchronous input level
//   q_o   - synchronised output (last stage), STAGES edges behind d_i
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_controller.sv
// exc_controller: sequences the exception path of the single-cycle datapath.
// Takes an external interrupt (synchronised here), the invalid-opcode flag and
// the decoded ERET, raises Exc until the datapath acknowledges, tracks the
// handler, and issues ERet on return. Double faults and missing acks latch a
// sticky fault that only reset clears.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   ExtIRQ    - external interrupt level, asynchronous to clk
//   InvalidOp - current instruction has an undefined opcode
//   ERetInstr - current instruction decodes as ERET
//   ExcAck    - datapath has loaded the exception vector into the PC
//   Exc       - exception request (registered)
//   ERet      - return-from-exception (combinational)
//   EStatus   - 4-bit cause code (registered)
//   InHandler - handler executing (registered)
//   Fault     - sticky fault flag (registered)
module exc_controller
   import exc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACK_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ExtIRQ,
   input  logic       InvalidOp,
   input  logic       ERetInstr,
   input  logic       ExcAck,
   output logic       Exc,
   output logic       ERet,
   output logic [3:0] EStatus,
   output logic       InHandler,
   output logic       Fault
);

   // Counter value of the last PENDING cycle tolerated without an ack.
   localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

   exc_state_t state_q, state_d;
   logic [3:0] estatus_q, estatus_d;
   logic [7:0] cnt_q, cnt_d;
   logic       irq_s;
   logic       eret;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_irq_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (ExtIRQ),
      .q_o  (irq_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         estatus_q <= CAUSE_NONE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         estatus_q <= estatus_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      estatus_d = estatus_q;
      cnt_d     = cnt_q;
      eret      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (InvalidOp) begin
               state_d   = PENDING;
               estatus_d = CAUSE_INVOP;
            end else if (ERetInstr) begin
               state_d   = PENDING;
               estatus_d = CAUSE_ERET;
            end else if (irq_s) begin
               state_d   = PENDING;
               estatus_d = CAUSE_EXTIRQ;
            end
         end
         PENDING: begin
            // New causes are ignored here; the latched cause stays.
            if (ExcAck) begin
               state_d = HANDLER;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d   = FAULT;
               estatus_d = CAUSE_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HANDLER: begin
            // irq_s is masked; a fault inside the handler beats a return.
            if (InvalidOp) begin
               state_d   = FAULT;
               estatus_d = CAUSE_FAULT;
            end else if (ERetInstr) begin
               eret      = 1'b1;
               state_d   = IDLE;
               estatus_d = CAUSE_NONE;
            end
         end
         FAULT: begin
            estatus_d = CAUSE_FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   assign Exc       = (state_q == PENDING);
   assign InHandler = (state_q == HANDLER);
   assign Fault     = (state_q == FAULT);
   assign EStatus   = estatus_q;
   assign ERet      = eret;

endmodule

// File: tb/tb_exc_controller.sv
module tb_exc_controller;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned ACK_TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ExtIRQ = 1'b0;
   logic       InvalidOp = 1'b0;
   logic       ERetInstr = 1'b0;
   logic       ExcAck = 1'b0;
   logic       Exc;
   logic       ERet;
   logic [3:0] EStatus;
   logic       InHandler;
   logic       Fault;

   int errors = 0;
   int checks = 0;

   exc_controller #(
      .SYNC_STAGES(SYNC_STAGES),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ExtIRQ   (ExtIRQ),
      .InvalidOp(InvalidOp),
      .ERetInstr(ERetInstr),
      .ExcAck   (ExcAck),
      .Exc      (Exc),
      .ERet     (ERet),
      .EStatus  (EStatus),
      .InHandler(InHandler),
      .Fault    (Fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       irq;
      logic       inv;
      logic       eret;
      logic       ack;
      logic       exc;
      logic       ret;
      logic [3:0] est;
      logic       inh;
      logic       flt;
   } vec_t;

   function automatic vec_t v(input logic rst, input logic irq, input logic inv,
                              input logic eret, input logic ack, input logic exc,
                              input logic ret, input logic [3:0] est, input logic inh,
                              input logic flt);
      vec_t r;
      r.rst = rst; r.irq = irq; r.inv = inv; r.eret = eret; r.ack = ack;
      r.exc = exc; r.ret = ret; r.est = est; r.inh = inh; r.flt = flt;
      return r;
   endfunction

   task automatic drive(input logic rst, input logic irq, input logic inv, input logic eret,
                        input logic ack);
      reset = rst; ExtIRQ = irq; InvalidOp = inv; ERetInstr = eret; ExcAck = ack;
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic exc, input logic ret,
                      input logic [3:0] est, input logic inh, input logic flt);
      checks++;
      if ({Exc, ERet, EStatus, InHandler, Fault} !== {exc, ret, est, inh, flt}) begin
         errors++;
         $display("FAIL %s: got Exc=%b ERet=%b EStatus=%b InHandler=%b Fault=%b, want Exc=%b ERet=%b EStatus=%b InHandler=%b Fault=%b",
                  name, Exc, ERet, EStatus, InHandler, Fault, exc, ret, est, inh, flt);
      end
   endtask

   vec_t tbl[34];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // Each row: inputs held for one cycle, outputs expected in that cycle (before the edge).
      //            rst irq inv ert ack  exc ret est    inh flt
      tbl[0]  = v(1, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[1]  = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      // invalid opcode, ack on 3rd pending cycle, return
      tbl[2]  = v(0, 0, 1, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[3]  = v(0, 0, 0, 0, 0,  1, 0, 4'h1, 0, 0);
      tbl[4]  = v(0, 0, 0, 0, 0,  1, 0, 4'h1, 0, 0);
      tbl[5]  = v(0, 0, 0, 0, 1,  1, 0, 4'h1, 0, 0);
      tbl[6]  = v(0, 0, 0, 0, 0,  0, 0, 4'h1, 1, 0);
      tbl[7]  = v(0, 0, 0, 1, 0,  0, 1, 4'h1, 1, 0);
      tbl[8]  = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      // ack in IDLE is ignored
      tbl[9]  = v(0, 0, 0, 0, 1,  0, 0, 4'h0, 0, 0);
      tbl[10] = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      // ERET outside handler
      tbl[11] = v(0, 0, 0, 1, 0,  0, 0, 4'h0, 0, 0);
      tbl[12] = v(0, 0, 0, 0, 1,  1, 0, 4'h3, 0, 0);
      tbl[13] = v(0, 0, 0, 1, 0,  0, 1, 4'h3, 1, 0);
      tbl[14] = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      // priority with all three causes, then level irq re-taken after return
      tbl[15] = v(0, 1, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[16] = v(0, 1, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[17] = v(0, 1, 1, 1, 0,  0, 0, 4'h0, 0, 0);
      tbl[18] = v(0, 1, 0, 0, 0,  1, 0, 4'h1, 0, 0);
      tbl[19] = v(0, 1, 0, 0, 1,  1, 0, 4'h1, 0, 0);
      tbl[20] = v(0, 1, 0, 0, 0,  0, 0, 4'h1, 1, 0);
      tbl[21] = v(0, 1, 0, 1, 0,  0, 1, 4'h1, 1, 0);
      tbl[22] = v(0, 1, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[23] = v(0, 0, 0, 0, 1,  1, 0, 4'h2, 0, 0);
      tbl[24] = v(0, 0, 0, 0, 0,  0, 0, 4'h2, 1, 0);
      tbl[25] = v(0, 0, 0, 1, 0,  0, 1, 4'h2, 1, 0);
      tbl[26] = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      // invalid opcode inside handler beats ERET
      tbl[27] = v(0, 0, 1, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[28] = v(0, 0, 0, 0, 1,  1, 0, 4'h1, 0, 0);
      tbl[29] = v(0, 0, 1, 1, 0,  0, 0, 4'h1, 1, 0);
      tbl[30] = v(0, 0, 0, 0, 0,  0, 0, 4'hF, 0, 1);
      tbl[31] = v(0, 1, 1, 1, 1,  0, 0, 4'hF, 0, 1);
      tbl[32] = v(1, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);
      tbl[33] = v(0, 0, 0, 0, 0,  0, 0, 4'h0, 0, 0);

      // Reset with ExtIRQ held: outputs stay 0, then interrupt taken after the synchroniser.
      #1;
      drive(1, 1, 0, 0, 0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_irq_hold%0d", i), 0, 0, 4'h0, 0, 0);
         tick();
      end
      drive(0, 1, 0, 0, 0);
      #1;
      chk("rst_release", 0, 0, 4'h0, 0, 0);
      for (int k = 1; k <= int'(SYNC_STAGES); k++) begin
         tick();
         chk($sformatf("irq_sync_edge%0d", k), 0, 0, 4'h0, 0, 0);
      end
      tick();
      chk("irq_taken", 1, 0, 4'h2, 0, 0);

      // Table-driven sequences.
      for (int i = 0; i < 34; i++) begin
         drive(tbl[i].rst, tbl[i].irq, tbl[i].inv, tbl[i].eret, tbl[i].ack);
         #1;
         chk($sformatf("row%0d", i), tbl[i].exc, tbl[i].ret, tbl[i].est, tbl[i].inh,
             tbl[i].flt);
         tick();
      end

      // Ack timeout: Exc high for exactly ACK_TIMEOUT cycles, then sticky fault.
      begin
         int n;
         drive(0, 0, 1, 0, 0);
         tick();
         drive(0, 0, 0, 0, 0);
         n = 0;
         while (Exc === 1'b1 && n < 20) begin
            n++;
            tick();
         end
         checks++;
         if (n != int'(ACK_TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_len: got %0d pending cycles, want %0d", n, ACK_TIMEOUT);
         end
         chk("timeout_fault", 0, 0, 4'hF, 0, 1);
         for (int i = 0; i < 3; i++) begin
            drive(0, 1, i == 0, i == 1, 1);
            #1;
            chk($sformatf("fault_sticky%0d", i), 0, 0, 4'hF, 0, 1);
            tick();
         end
         drive(1, 0, 0, 0, 0);
         #1;
         chk("fault_reset", 0, 0, 4'h0, 0, 0);
         tick();
      end

      // Asynchronous reset mid-PENDING.
      drive(0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("pend_before_rst", 1, 0, 4'h1, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      chk("pend_async_rst", 0, 0, 4'h0, 0, 0);
      tick();

      // Asynchronous reset mid-HANDLER.
      drive(0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      chk("hand_before_rst", 0, 0, 4'h1, 1, 0);
      drive(1, 0, 0, 0, 0);
      #1;
      chk("hand_async_rst", 0, 0, 4'h0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      chk("idle_after_rst", 0, 0, 4'h0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
